move_score_sequencer: RTL and testbench

//  Controls the pixel-match scoring datapath for one song.
//  - Walks the song through its dance moves. Each move is a fixed number of video frames.
//  - During a move, asserts the scorer's counting enable only while the camera pixel is in the region of interest.
//  - At the end of each move, holds counting and update high together so the scorer commits its move points.
//  - Sits between video timing (frame_start, in_roi) and the scorer. Drives the move index to the choreography display.

---
 rtl/move_score_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_move_score_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/move_score_sequencer.sv
// ---------------------------------------------------------------------------
// move_score_sequencer
//
// Purpose:
//   Sequences the pixel-match scorer through one song. After a lead-in of
//   LEAD_FRAMES video frames it walks NUM_MOVES dance moves, each lasting
//   FRAMES_PER_MOVE frames. While a move is being scored the scorer's count
//   enable follows the region-of-interest flag. At the end of every move,
//   counting and update are held high together for UPDATE_HOLD cycles so the
//   scorer can commit that move's points.
//
// Ports:
//   clk          in   system clock, single domain
//   reset        in   synchronous, active-high
//   start        in   1-cycle pulse, begins a song (IDLE or DONE only)
//   pause        in   level, freezes frame progress and counting
//   frame_start  in   1-cycle pulse at the start of each video frame
//   in_roi       in   current pixel lies inside the scored region
//   counting     out  scorer count enable (registered)
//   update       out  scorer commit request (registered)
//   move_idx     out  current move index, saturates at NUM_MOVES-1
//   busy         out  high in LEAD_IN, SCORE and COMMIT
//   done         out  song finished, held until the next start
// ---------------------------------------------------------------------------
module move_score_sequencer #(
  parameter int unsigned NUM_MOVES       = 16,
  parameter int unsigned FRAMES_PER_MOVE = 60,
  parameter int unsigned LEAD_FRAMES     = 30,
  parameter int unsigned UPDATE_HOLD     = 20,
  // Derived widths; not meant to be overridden.
  parameter int unsigned MW = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic          frame_start,
  input  logic          in_roi,
  output logic          counting,
  output logic          update,
  output logic [MW-1:0] move_idx,
  output logic          busy,
  output logic          done
);

  // One frame counter serves both lead-in and scoring windows, so it is
  // sized for the longer of the two.
  localparam int unsigned FRAME_MAX = (LEAD_FRAMES > FRAMES_PER_MOVE) ?
                                      LEAD_FRAMES : FRAMES_PER_MOVE;
  localparam int unsigned FW = $clog2(FRAME_MAX + 1);
  localparam int unsigned HW = $clog2(UPDATE_HOLD + 1);

  // Terminal values: the counter is compared against "last" so that the
  // pulse which would make it equal the parameter triggers the transition,
  // and the counter itself never exceeds its parameter.
  localparam logic [FW-1:0] LEAD_LAST  = FW'(LEAD_FRAMES - 1);
  localparam logic [FW-1:0] SCORE_LAST = FW'(FRAMES_PER_MOVE - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(UPDATE_HOLD - 1);
  localparam logic [MW-1:0] MOVE_LAST  = MW'(NUM_MOVES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_IN,
    S_SCORE,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [FW-1:0] r_frame_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [MW-1:0] r_move_idx;
  logic          r_counting;
  logic          r_update;
  logic          r_busy;
  logic          r_done;

  // A frame only advances the song when the sequence is not paused.
  logic w_frame_tick;
  assign w_frame_tick = frame_start & ~pause;

  // NOTE: every register, including the counters, is cleared by reset so the
  // block returns to a known IDLE from any state, even mid-COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
      r_hold_cnt  <= '0;
      r_move_idx  <= '0;
      r_counting  <= 1'b0;
      r_update    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge values of the state and counters.
      case (r_state)
        S_IDLE, S_DONE: begin
          r_counting <= 1'b0;
          r_update   <= 1'b0;
          // A frame_start coinciding with start is not counted: the frame
          // counter is cleared here regardless.
          if (start) begin
            r_state     <= S_LEAD_IN;
            r_frame_cnt <= '0;
            r_move_idx  <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end

        S_LEAD_IN: begin
          r_counting <= 1'b0;
          r_update   <= 1'b0;
          if (w_frame_tick) begin
            if (r_frame_cnt == LEAD_LAST) begin
              r_state     <= S_SCORE;
              r_frame_cnt <= '0;
            end else begin
              r_frame_cnt <= r_frame_cnt + FW'(1);
            end
          end
        end

        S_SCORE: begin
          r_update   <= 1'b0;
          r_counting <= in_roi & ~pause;
          if (w_frame_tick) begin
            if (r_frame_cnt == SCORE_LAST) begin
              // Raise both strobes together with the state change so they
              // are high for the whole of COMMIT.
              r_state    <= S_COMMIT;
              r_hold_cnt <= '0;
              r_counting <= 1'b1;
              r_update   <= 1'b1;
            end else begin
              r_frame_cnt <= r_frame_cnt + FW'(1);
            end
          end
        end

        S_COMMIT: begin
          // pause and frame_start have no effect here; the hold length is
          // fixed so the scorer always reaches its commit state.
          if (r_hold_cnt == HOLD_LAST) begin
            r_counting <= 1'b0;
            r_update   <= 1'b0;
            if (r_move_idx == MOVE_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_SCORE;
              r_move_idx  <= r_move_idx + MW'(1);
              r_frame_cnt <= '0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
            r_counting <= 1'b1;
            r_update   <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_counting <= 1'b0;
          r_update   <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign counting = r_counting;
  assign update   = r_update;
  assign move_idx = r_move_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_move_score_sequencer.sv
// ---------------------------------------------------------------------------
// tb_move_score_sequencer
//
// Self-checking bench for move_score_sequencer with NUM_MOVES=2,
// FRAMES_PER_MOVE=3, LEAD_FRAMES=2, UPDATE_HOLD=4. A hand-derived vector
// table covers reset, lead-in and the first move's commit; hand-written
// sequences cover pause, song end, restart from DONE and reset mid-COMMIT;
// a randomized run is then checked against a countdown-based reference model.
// Outputs are packed as {counting, update, move_idx, busy, done}.
// ---------------------------------------------------------------------------
module tb_move_score_sequencer;

  localparam int NM   = 2;
  localparam int FPM  = 3;
  localparam int LEAD = 2;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, pause = 1'b0, frame_start = 1'b0, in_roi = 1'b0;
  logic counting, update, busy, done;
  logic [0:0] move_idx;

  always #5 clk = ~clk;

  move_score_sequencer #(
    .NUM_MOVES      (NM),
    .FRAMES_PER_MOVE(FPM),
    .LEAD_FRAMES    (LEAD),
    .UPDATE_HOLD    (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .frame_start(frame_start),
    .in_roi     (in_roi),
    .counting   (counting),
    .update     (update),
    .move_idx   (move_idx),
    .busy       (busy),
    .done       (done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {cnt,upd,mv,busy,done}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_out();
    return {counting, update, move_idx, busy, done};
  endfunction

  // ---------------- reference model ----------------
  // Song position is tracked as a phase plus "frames remaining" and
  // "hold cycles remaining" countdowns.
  typedef enum int { P_IDLE, P_LEAD, P_SCORE, P_COMMIT, P_DONE } phase_t;
  phase_t m_phase = P_IDLE;
  int m_frames_left = 0, m_hold_left = 0, m_move = 0;
  logic m_cnt = 0, m_upd = 0, m_busy = 0, m_done = 0;

  task automatic model_edge(input logic rst, st, ps, fs, roi);
    logic tick;
    tick = fs && !ps;
    if (rst) begin
      m_phase = P_IDLE; m_move = 0; m_cnt = 0; m_upd = 0; m_busy = 0; m_done = 0;
      return;
    end
    m_cnt = 0;
    m_upd = 0;
    case (m_phase)
      P_IDLE, P_DONE:
        if (st) begin
          m_phase = P_LEAD; m_frames_left = LEAD; m_move = 0; m_busy = 1; m_done = 0;
        end
      P_LEAD:
        if (tick) begin
          m_frames_left--;
          if (m_frames_left == 0) begin m_phase = P_SCORE; m_frames_left = FPM; end
        end
      P_SCORE: begin
        m_cnt = roi && !ps;
        if (tick) begin
          m_frames_left--;
          if (m_frames_left == 0) begin
            m_phase = P_COMMIT; m_hold_left = HOLD; m_cnt = 1; m_upd = 1;
          end
        end
      end
      P_COMMIT: begin
        m_hold_left--;
        if (m_hold_left > 0) begin
          m_cnt = 1; m_upd = 1;
        end else if (m_move == NM - 1) begin
          m_phase = P_DONE; m_busy = 0; m_done = 1;
        end else begin
          m_move++; m_phase = P_SCORE; m_frames_left = FPM;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  function automatic logic [4:0] model_out();
    return {m_cnt, m_upd, 1'(m_move), m_busy, m_done};
  endfunction

  // Apply one cycle of inputs, advance model at the edge, compare #1 later.
  task automatic step(input logic rst, st, ps, fs, roi);
    reset = rst; start = st; pause = ps; frame_start = fs; in_roi = roi;
    @(posedge clk);
    model_edge(rst, st, ps, fs, roi);
    #1;
    check("model", dut_out(), model_out());
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, st, ps, fs, roi;
    logic [4:0] exp;   // {cnt, upd, mv, busy, done}
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Expected outputs after the edge that samples each row's inputs.
    tbl[0]  = '{1, 0, 0, 0, 0, 5'b00000}; // reset
    tbl[1]  = '{0, 0, 0, 1, 0, 5'b00000}; // frame in IDLE: nothing
    tbl[2]  = '{0, 1, 0, 1, 0, 5'b00010}; // start+frame: LEAD_IN, frame not counted
    tbl[3]  = '{0, 0, 0, 1, 0, 5'b00010}; // lead frame 1
    tbl[4]  = '{0, 0, 0, 0, 1, 5'b00010}; // in_roi in LEAD_IN: no counting
    tbl[5]  = '{0, 0, 0, 1, 0, 5'b00010}; // lead frame 2 -> SCORE
    tbl[6]  = '{0, 0, 0, 0, 1, 5'b10010}; // in_roi=1 -> counting
    tbl[7]  = '{0, 0, 0, 0, 0, 5'b00010}; // in_roi=0 -> no counting
    tbl[8]  = '{0, 0, 1, 0, 1, 5'b00010}; // paused -> no counting
    tbl[9]  = '{0, 0, 0, 1, 1, 5'b10010}; // score frame 1
    tbl[10] = '{0, 0, 0, 1, 0, 5'b00010}; // score frame 2
    tbl[11] = '{0, 0, 0, 1, 1, 5'b11010}; // score frame 3 -> COMMIT cycle 1
    tbl[12] = '{0, 1, 0, 0, 0, 5'b11010}; // start ignored, COMMIT cycle 2
    tbl[13] = '{0, 0, 1, 1, 0, 5'b11010}; // pause/frame ignored, cycle 3
    tbl[14] = '{0, 0, 0, 0, 0, 5'b11010}; // cycle 4
    tbl[15] = '{0, 0, 0, 0, 0, 5'b00110}; // exit: move 1, SCORE
    tbl[16] = '{0, 0, 0, 0, 1, 5'b10110}; // counting in move 1
  end

  initial begin
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].ps, tbl[i].fs, tbl[i].roi);
      check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
    end

    // Pause across 5 frames in move 1: no counting, no commit.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1, 1);
      check("pause_hold", dut_out(), 5'b00110);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("pause_release_2", dut_out(), 5'b00110);
    step(0, 0, 0, 1, 0);
    check("pause_release_commit", dut_out(), 5'b11110);
    for (int i = 0; i < HOLD - 1; i++) step(0, 0, 0, 0, 1);
    check("last_commit_hold", dut_out(), 5'b11110);

    // End of song: done held, counting stays low with in_roi=1.
    step(0, 0, 0, 0, 1);
    check("song_done", dut_out(), 5'b00101);
    step(0, 0, 0, 1, 1);
    check("done_held", dut_out(), 5'b00101);

    // Restart from DONE.
    step(0, 1, 0, 0, 0);
    check("restart_from_done", dut_out(), 5'b00010);

    // Play move 0, then reset during the 2nd cycle of move 1's COMMIT.
    for (int i = 0; i < LEAD; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < FPM; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < HOLD; i++) step(0, 0, 0, 0, 0);
    check("second_song_move1", dut_out(), 5'b00110);
    for (int i = 0; i < FPM; i++) step(0, 0, 0, 1, 1);
    check("commit_cycle1", dut_out(), 5'b11110);
    step(0, 0, 0, 0, 1);
    check("commit_cycle2", dut_out(), 5'b11110);
    step(1, 0, 0, 0, 1);
    check("reset_mid_commit", dut_out(), 5'b00000);
    step(0, 0, 0, 1, 1);
    check("idle_after_reset", dut_out(), 5'b00000);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
